booth_check_sequencer: RTL

Self-checking sequencer for the radix-4 Booth multiplier set. It drives a shared operand pair A/B into the three Booth variants (V1 → Y, parallel assign → X, V2 → W) and the reference multiplier (→ S). After a settle window it compares each variant's product against S. It keeps per-variant mismatch counters and captures the first failing operand pair. It sits beside the multiplier driver as its stimulus and checking controller.

---
 rtl/booth_check_pkg.sv | 14 +
 rtl/booth_vec_gen.sv | 24 ++
 rtl/booth_check_sequencer.sv | 103 ++++++++++
 3 files changed

// File: rtl/booth_check_pkg.sv
// booth_check_pkg: sequencer state encoding, LFSR taps and saturating increment
package booth_check_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_COMPARE, ST_DONE} state_t;
    function automatic logic [127:0] lfsr_taps(input int width);
        return width == 8   ? 128'hB8 :
               width == 16  ? 128'hB400 :
               width == 32  ? 128'hA300_0000 :
               width == 64  ? 128'hD800_0000_0000_0000 :
               width == 128 ? 128'hE100_0000_0000_0000_0000_0000_0000_0000 : 128'h0;
    endfunction
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
        return v == max ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/booth_vec_gen.sv
// booth_vec_gen: {B,A} operand generator, incrementing counter or right-shift Galois LFSR
module booth_vec_gen import booth_check_pkg::*; #(
    parameter int W    = 8,
    parameter int MODE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] seed,
    output logic [W-1:0] vec
);
    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));
    logic [W-1:0] nxt;
    assign nxt = MODE == 1 ? (vec >> 1) ^ (vec[0] ? TAPS : '0) : vec + W'(1);
    always_ff @(posedge clk) begin
        if (!rst_n)
            vec <= '0;
        else if (load)
            vec <= (MODE == 1 && seed == '0) ? W'(1) : seed;
        else if (step)
            vec <= nxt;
    end
endmodule

// File: rtl/booth_check_sequencer.sv
// booth_check_sequencer: drives shared operands into the Booth variants and checks them against the reference product
module booth_check_sequencer import booth_check_pkg::*; #(
    parameter int TAM    = 4,
    parameter int NVEC   = 256,
    parameter int SETTLE = 2,
    parameter int MODE   = 0,
    parameter int CW     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2*TAM-1:0]      seed,
    input  logic signed [2*TAM-1:0] Y,
    input  logic signed [2*TAM-1:0] X,
    input  logic signed [2*TAM-1:0] W,
    input  logic signed [2*TAM-1:0] S,
    output logic [TAM-1:0]        A,
    output logic [TAM-1:0]        B,
    output logic                  busy,
    output logic                  done,
    output logic [CW-1:0]         err_y,
    output logic [CW-1:0]         err_x,
    output logic [CW-1:0]         err_w,
    output logic [2:0]            fail_mask,
    output logic [TAM-1:0]        first_a,
    output logic [TAM-1:0]        first_b,
    output logic                  first_valid
);
    localparam int SW = $clog2(SETTLE + 1);
    localparam int IW = $clog2(NVEC + 1);
    localparam logic [CW-1:0] CMAX = '1;
    state_t         state;
    logic [SW-1:0]  scnt;
    logic [IW-1:0]  idx;
    logic [2*TAM-1:0] vec;
    logic [2:0]     mis;
    assign {B, A} = vec;
    assign mis = {W != S, X != S, Y != S};
    assign busy = state != ST_IDLE || start;
    booth_vec_gen #(.W(2*TAM), .MODE(MODE)) u_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .load (state == ST_IDLE && start),
        .step (state == ST_COMPARE),
        .seed (seed),
        .vec  (vec)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            scnt        <= '0;
            idx         <= '0;
            done        <= 1'b0;
            err_y       <= '0;
            err_x       <= '0;
            err_w       <= '0;
            fail_mask   <= '0;
            first_a     <= '0;
            first_b     <= '0;
            first_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    state       <= ST_SETTLE;
                    scnt        <= SW'(SETTLE - 1);
                    idx         <= '0;
                    err_y       <= '0;
                    err_x       <= '0;
                    err_w       <= '0;
                    fail_mask   <= '0;
                    first_a     <= '0;
                    first_b     <= '0;
                    first_valid <= 1'b0;
                end
                ST_SETTLE: begin
                    scnt <= scnt - SW'(1);
                    if (scnt == '0) state <= ST_COMPARE;
                end
                ST_COMPARE: begin
                    if (mis[0]) err_y <= CW'(sat_inc(32'(err_y), 32'(CMAX)));
                    if (mis[1]) err_x <= CW'(sat_inc(32'(err_x), 32'(CMAX)));
                    if (mis[2]) err_w <= CW'(sat_inc(32'(err_w), 32'(CMAX)));
                    fail_mask <= fail_mask | mis;
                    if (|mis && !first_valid) begin
                        first_a     <= A;
                        first_b     <= B;
                        first_valid <= 1'b1;
                    end
                    idx <= idx + IW'(1);
                    if (idx == IW'(NVEC - 1)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= ST_SETTLE;
                        scnt  <= SW'(SETTLE - 1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
